// File: rtl/rs_chien_stream_pkg.sv
// rs_chien_stream_pkg: GF(2^8) arithmetic, Chien search constants and FSM state type.
package rs_chien_stream_pkg;

    localparam int SYMB_WIDTH = 8;
    localparam int SYMB_NUM   = 1 << SYMB_WIDTH;
    localparam int T_LEN      = 8;
    localparam int N_LEN_DEF  = 255;
    localparam int RPC_DEF    = 32;
    localparam int CNT_W      = $clog2(T_LEN + 1);
    localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11d;

    typedef logic [SYMB_WIDTH-1:0] symb_t;
    typedef logic [T_LEN:0][SYMB_WIDTH-1:0] lambda_t;
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    function automatic int chien_cycles(input int n, input int rpc);
        return (n + rpc - 1) / rpc;
    endfunction

    function automatic symb_t gf_mul(input symb_t a, input symb_t b);
        logic [SYMB_WIDTH:0] x;
        symb_t r;
        x = {1'b0, a};
        r = '0;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) r = r ^ x[SYMB_WIDTH-1:0];
            x = x << 1;
            if (x[SYMB_WIDTH]) x = x ^ PRIM_POLY;
        end
        return r;
    endfunction

    function automatic logic [SYMB_NUM*SYMB_WIDTH-1:0] alpha_rom();
        logic [SYMB_NUM*SYMB_WIDTH-1:0] t;
        symb_t a;
        t = '0;
        a = symb_t'(1);
        for (int i = 0; i < SYMB_NUM; i++) begin
            t[i*SYMB_WIDTH +: SYMB_WIDTH] = a;
            a = gf_mul(a, symb_t'(2));
        end
        return t;
    endfunction

    localparam logic [SYMB_NUM*SYMB_WIDTH-1:0] ALPHA_ROM = alpha_rom();

    function automatic symb_t alpha_to_symb(input symb_t e);
        return ALPHA_ROM[int'(e)*SYMB_WIDTH +: SYMB_WIDTH];
    endfunction

    function automatic symb_t gf_eval(input lambda_t lam, input symb_t x);
        symb_t r;
        r = lam[T_LEN];
        for (int i = T_LEN - 1; i >= 0; i--) r = gf_mul(r, x) ^ lam[i];
        return r;
    endfunction

endpackage

// File: rtl/rs_chien_compact.sv
// rs_chien_compact: packs one cycle of root hits into consecutive result slots after the current fill.
module rs_chien_compact
    import rs_chien_stream_pkg::*;
#(
    parameter int RPC = RPC_DEF
) (
    input  logic [RPC-1:0]                  hits,
    input  symb_t                           base,
    input  logic [CNT_W-1:0]                fill,
    output logic [T_LEN-1:0]                wen,
    output logic [T_LEN-1:0][SYMB_WIDTH-1:0] wdata,
    output logic [CNT_W-1:0]                count,
    output logic                            ovf
);

    always_comb begin
        int n;
        n = int'(fill);
        wen = '0;
        wdata = '0;
        ovf = 1'b0;
        for (int k = 0; k < RPC; k++) begin
            if (hits[k]) begin
                if (n < T_LEN) begin
                    wen[n] = 1'b1;
                    wdata[n] = base + symb_t'(k);
                    n = n + 1;
                end else begin
                    ovf = 1'b1;
                end
            end
        end
        count = CNT_W'(n);
    end

endmodule

// File: rtl/rs_chien_stream.sv
// rs_chien_stream: streaming Chien search, ROOTS_PER_CYCLE positions per cycle with packed
// ascending root positions, root count and failure flag, valid/ready on both sides.
module rs_chien_stream
    import rs_chien_stream_pkg::*;
#(
    parameter int N_LEN           = N_LEN_DEF,
    parameter int ROOTS_PER_CYCLE = RPC_DEF
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [T_LEN:0][SYMB_WIDTH-1:0]   error_locator,
    input  logic [CNT_W-1:0]                 error_locator_deg,
    input  logic                             error_locator_vld,
    output logic                             error_locator_rdy,
    output logic [T_LEN-1:0][SYMB_WIDTH-1:0] error_positions,
    output logic [T_LEN-1:0]                 error_positions_mask,
    output logic [CNT_W-1:0]                 error_count,
    output logic                             error_positions_vld,
    input  logic                             error_positions_rdy,
    output logic                             rs_chien_err
);

    localparam int CYCLES = chien_cycles(N_LEN, ROOTS_PER_CYCLE);
    localparam int C_W    = CYCLES > 1 ? $clog2(CYCLES) : 1;

    state_t                           state_q, state_d;
    logic [C_W-1:0]                   c_q, c_d;
    lambda_t                          lam_q, lam_d;
    logic [CNT_W-1:0]                 deg_q, deg_d;
    logic [ROOTS_PER_CYCLE-1:0]       hit_q, hit_d;
    symb_t                            base_q, base_d;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_q, pos_d;
    logic [T_LEN-1:0]                 mask_q, mask_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             ovf_q, ovf_d;
    logic [T_LEN-1:0]                 wen;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] wdata;
    logic [CNT_W-1:0]                 new_cnt;
    logic                             new_ovf;
    logic                             acc;

    // Lane k tests alpha^-p; lanes past the (possibly shortened) codeword never hit.
    always_comb begin
        int p, e;
        p = 0;
        e = 0;
        hit_d = '0;
        for (int k = 0; k < ROOTS_PER_CYCLE; k++) begin
            p = int'(c_q) * ROOTS_PER_CYCLE + k;
            e = (SYMB_NUM - 1 - p % (SYMB_NUM - 1)) % (SYMB_NUM - 1);
            hit_d[k] = (state_q == SCAN) && (p < N_LEN) &&
                       (gf_eval(lam_q, alpha_to_symb(symb_t'(e))) == '0);
        end
    end

    rs_chien_compact #(.RPC(ROOTS_PER_CYCLE)) u_compact (
        .hits  (hit_q),
        .base  (base_q),
        .fill  (cnt_q),
        .wen   (wen),
        .wdata (wdata),
        .count (new_cnt),
        .ovf   (new_ovf)
    );

    assign error_locator_rdy = aresetn && ((state_q == IDLE) || (state_q == DONE && error_positions_rdy));
    assign acc = error_locator_vld && error_locator_rdy;

    always_comb begin
        state_d = state_q;
        c_d = c_q;
        lam_d = lam_q;
        deg_d = deg_q;
        base_d = symb_t'(int'(c_q) * ROOTS_PER_CYCLE);
        pos_d = pos_q;
        mask_d = mask_q;
        for (int i = 0; i < T_LEN; i++) begin
            pos_d[i] = wen[i] ? wdata[i] : pos_q[i];
            mask_d[i] = mask_q[i] | wen[i];
        end
        cnt_d = new_cnt;
        ovf_d = ovf_q | new_ovf;
        if (state_q == SCAN) begin
            state_d = (c_q == C_W'(CYCLES - 1)) ? FLUSH : SCAN;
            c_d = (c_q == C_W'(CYCLES - 1)) ? c_q : c_q + C_W'(1);
        end
        if (state_q == FLUSH) state_d = DONE;
        if (state_q == DONE && error_positions_rdy) state_d = IDLE;
        if (acc) begin
            state_d = SCAN;
            c_d = '0;
            lam_d = error_locator;
            deg_d = error_locator_deg;
            pos_d = '0;
            mask_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            c_q <= '0;
            lam_q <= '0;
            deg_q <= '0;
            hit_q <= '0;
            base_q <= '0;
            pos_q <= '0;
            mask_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q <= c_d;
            lam_q <= lam_d;
            deg_q <= deg_d;
            hit_q <= hit_d;
            base_q <= base_d;
            pos_q <= pos_d;
            mask_q <= mask_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign error_positions      = pos_q;
    assign error_positions_mask = mask_q;
    assign error_count          = cnt_q;
    assign error_positions_vld  = (state_q == DONE);
    assign rs_chien_err         = ovf_q || (cnt_q != deg_q) || (deg_q > CNT_W'(T_LEN));

endmodule

// File: tb/tb_rs_chien_stream.sv
// tb_rs_chien_stream: directed checks of the streaming Chien search on RS(255,239) and a shortened N_LEN=204 instance.
module tb_rs_chien_stream;
    import rs_chien_stream_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    lambda_t                          lam;
    logic [CNT_W-1:0]                 deg;
    logic                             vld, ordy, sel;
    logic                             rdy0, rdy1, ovld0, ovld1, err0, err1;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos0, pos1;
    logic [T_LEN-1:0]                 mask0, mask1;
    logic [CNT_W-1:0]                 cnt0, cnt1;
    logic                             o_rdy, o_vld, o_err;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] o_pos;
    logic [T_LEN-1:0]                 o_mask;
    logic [CNT_W-1:0]                 o_cnt;
    int                               n_tests = 0;
    int                               n_fail = 0;
    int                               n;

    rs_chien_stream dut0 (
        .aclk(aclk), .aresetn(aresetn), .error_locator(lam), .error_locator_deg(deg),
        .error_locator_vld(vld && !sel), .error_locator_rdy(rdy0), .error_positions(pos0),
        .error_positions_mask(mask0), .error_count(cnt0), .error_positions_vld(ovld0),
        .error_positions_rdy(ordy), .rs_chien_err(err0)
    );

    rs_chien_stream #(.N_LEN(204)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .error_locator(lam), .error_locator_deg(deg),
        .error_locator_vld(vld && sel), .error_locator_rdy(rdy1), .error_positions(pos1),
        .error_positions_mask(mask1), .error_count(cnt1), .error_positions_vld(ovld1),
        .error_positions_rdy(ordy), .rs_chien_err(err1)
    );

    assign o_rdy  = sel ? rdy1 : rdy0;
    assign o_vld  = sel ? ovld1 : ovld0;
    assign o_err  = sel ? err1 : err0;
    assign o_pos  = sel ? pos1 : pos0;
    assign o_mask = sel ? mask1 : mask0;
    assign o_cnt  = sel ? cnt1 : cnt0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            b = b >> 1;
            a = a[7] ? ((a << 1) ^ 8'h1d) : (a << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] apow(input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = mul(r, 8'h02);
        return r;
    endfunction

    // Multiplies lam by (1 + alpha^p x), placing a root at position p.
    task automatic add_root(input int p);
        for (int j = T_LEN; j >= 1; j--) lam[j] = lam[j] ^ mul(lam[j-1], apow(p));
    endtask

    task automatic set_lam(input int nr, input int r0, input int r1, input int r2);
        lam = '0;
        lam[0] = 8'h01;
        if (nr > 0) add_root(r0);
        if (nr > 1) add_root(r1);
        if (nr > 2) add_root(r2);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic accept();
        int i;
        i = 0;
        vld = 1'b1;
        while (!o_rdy && i < 50) begin
            tick();
            i++;
        end
        check("accept_rdy", o_rdy, 1);
        tick();
        vld = 1'b0;
    endtask

    task automatic wait_vld(output int cyc);
        cyc = 0;
        while (!o_vld && cyc < 50) begin
            tick();
            cyc++;
        end
        check("vld_timeout", o_vld, 1);
    endtask

    task automatic check_res(input string tag, input logic [63:0] p, input logic [7:0] m,
                             input int c, input logic e);
        check({tag, "_pos"}, o_pos, p);
        check({tag, "_mask"}, o_mask, m);
        check({tag, "_cnt"}, o_cnt, c);
        check({tag, "_err"}, o_err, e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vld = 1'b0;
        ordy = 1'b1;
        sel = 1'b0;
        lam = '0;
        deg = '0;
        tick();
        tick();
        check("rst_rdy", o_rdy, 0);
        check("rst_vld", o_vld, 0);
        check_res("rst", 0, 8'h00, 0, 0);
        aresetn = 1'b1;
        #1;
        check("rst_rel_rdy", o_rdy, 1);

        set_lam(0, 0, 0, 0);
        deg = 0;
        accept();
        wait_vld(n);
        check("t1_lat_cycles_incl_accept", n + 1, 10);
        check_res("t1", 0, 8'h00, 0, 0);

        set_lam(1, 5, 0, 0);
        deg = 1;
        accept();
        wait_vld(n);
        check_res("t2", 64'h05, 8'h01, 1, 0);

        set_lam(3, 30, 3, 200);
        deg = 3;
        accept();
        wait_vld(n);
        check_res("t3", 64'h00c8_1e03, 8'h07, 3, 0);

        lam = '0;
        deg = 0;
        accept();
        wait_vld(n);
        check_res("ovf", 64'h0706_0504_0302_0100, 8'hff, 8, 1);

        set_lam(0, 0, 0, 0);
        deg = 9;
        accept();
        wait_vld(n);
        check_res("deg_gt_t", 0, 8'h00, 0, 1);

        sel = 1'b1;
        set_lam(2, 203, 220, 0);
        deg = 2;
        accept();
        wait_vld(n);
        check("t4_lat_edges", n, 8);
        check_res("t4", 64'hcb, 8'h01, 1, 1);
        sel = 1'b0;

        ordy = 1'b0;
        set_lam(1, 5, 0, 0);
        deg = 1;
        accept();
        wait_vld(n);
        set_lam(3, 30, 3, 200);
        deg = 3;
        vld = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("t5_hold_rdy", o_rdy, 0);
            check("t5_hold_vld", o_vld, 1);
            check("t5_hold_pos", o_pos, 64'h05);
            check("t5_hold_cnt", o_cnt, 1);
            tick();
        end
        ordy = 1'b1;
        #1;
        check("t5_rdy_up", o_rdy, 1);
        tick();
        vld = 1'b0;
        check("t5_vld_drop", o_vld, 0);
        wait_vld(n);
        check("t5_lat_edges", n, 9);
        check_res("t5", 64'h00c8_1e03, 8'h07, 3, 0);

        set_lam(1, 5, 0, 0);
        deg = 1;
        accept();
        repeat (4) tick();
        aresetn = 1'b0;
        tick();
        check("t6_rst_rdy", o_rdy, 0);
        check("t6_rst_vld", o_vld, 0);
        check_res("t6_rst", 0, 8'h00, 0, 0);
        aresetn = 1'b1;
        #1;
        check("t6_rel_rdy", o_rdy, 1);
        accept();
        wait_vld(n);
        check("t6_lat_edges", n, 9);
        check_res("t6", 64'h05, 8'h01, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
